ftb_update_sched: RTL and testbench
===================================

FTB_UPDATE_SCHED -- requirements
Module: ftb_update_sched

Interface
REQ-001 SHALL have parameter SETS, default 512, meaning number of FTB sets (index width IW = log2(SETS)).
REQ-002 SHALL have parameter STARVE_LIMIT, default 8, meaning maximum consecutive cycles an update SRAM slot may be denied.
REQ-003 SHALL use one clock; reset is synchronous and active-high, ports named clk and rst.
REQ-004 clk  input  1  clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 i_pred_req  input  1  predictor lookup request this cycle.
REQ-007 i_pred_idx  input  IW  lookup set index.
REQ-008 o_pred_gnt  output  1  lookup granted the SRAM this cycle; lookup data is on i_sram_rdata next cycle.
REQ-009 i_upd_vld  input  1  update request valid.
REQ-010 o_upd_rdy  output  1  scheduler can accept an update.
REQ-011 i_upd_idx  input  IW  update set index.
REQ-012 i_upd_tag  input  FTB_TAG_WIDTH  update tag.
REQ-013 i_upd_info  input  BPupdateInfo_t  update payload; ftb_update.counter is ignored.
REQ-014 i_upd_taken  input  1  resolved direction.
REQ-015 o_sram_en  output  1  SRAM access strobe.
REQ-016 o_sram_we  output  1  write enable, 0 means read.
REQ-017 o_sram_addr  output  IW  SRAM set address.
REQ-018 o_sram_wdata  output  ftbEntry_t  write data.
REQ-019 i_sram_rdata  input  ftbEntry_t  read data, valid one cycle after a read strobe.
REQ-020 o_busy  output  1  update in flight (state not IDLE).

Function
REQ-021 SHALL share one single-port FTB SRAM between lookups and read-modify-write updates, with at most one access per cycle.
REQ-022 SHALL implement the FSM states IDLE, RD, WAIT, and WR.
REQ-023 SHALL assert o_upd_rdy only in IDLE.
REQ-024 On handshake (i_upd_vld and o_upd_rdy), SHALL latch idx, tag, info and taken, and go to RD.
REQ-025 In RD, SHALL issue a read of the latched idx when the update wins the slot, then go to WAIT; otherwise it SHALL stay in RD.
REQ-026 WAIT SHALL last exactly one cycle, SHALL capture i_sram_rdata into a merge register, and SHALL go to WR.
REQ-027 Hit is defined as rdata.vld=1 and rdata.tag equal to the latched tag.
REQ-028 On hit, wdata.info SHALL equal the latched ftb_update with counter set to the saturating 2-bit counter update of rdata.info.counter by taken: +1 saturating at 3, -1 saturating at 0.
REQ-029 On miss, wdata SHALL be {tag, vld=1, ftb_update} with counter=2 if taken, else 1.
REQ-030 In WR, SHALL issue the write when the update wins the slot, then go to IDLE; otherwise it SHALL stay in WR, holding the merge register.
REQ-031 The update SHALL win the slot if i_pred_req=0 or the starvation guard forces it (see Configuration); otherwise the lookup SHALL win.
REQ-032 o_pred_gnt SHALL equal i_pred_req and not (update wins in RD/WR); on grant: sram_en=1, we=0, addr=i_pred_idx.
REQ-033 The o_sram_en/o_sram_we/o_sram_addr/o_sram_wdata outputs SHALL be combinational from the current state and inputs; o_sram_wdata SHALL be don't-care unless we=1.
REQ-034 Minimum update latency with no lookups SHALL be handshake, RD, WAIT, WR: write strobe 3 cycles after handshake, o_upd_rdy high again on the 4th cycle.
REQ-035 A lookup to the same idx in the cycle after the write SHALL observe new data; no forwarding SHALL be provided for lookups in WAIT.

Reset
REQ-036 On rst, state SHALL become IDLE, the starvation counter 0, and any in-flight update SHALL be dropped without an SRAM write.
REQ-037 During and after reset: o_upd_rdy=1, o_busy=0, o_sram_en=0 unless a lookup is granted; o_pred_gnt follows REQ-032.

Configuration
REQ-038 Macro FTB_UPD_STARVE_GUARD_EN SHALL control the starvation guard.
REQ-039 With FTB_UPD_STARVE_GUARD_EN defined, a saturating counter SHALL increment each RD/WR cycle the update loses the slot and SHALL clear when the update wins.
REQ-040 With FTB_UPD_STARVE_GUARD_EN defined, when the counter reaches STARVE_LIMIT the update SHALL be forced to win and o_pred_gnt SHALL be 0 that cycle.
REQ-041 With FTB_UPD_STARVE_GUARD_EN undefined, no counter SHALL exist and lookups SHALL always win.

Verification
REQ-042 Idle bus, update idx=5 tag=0x3 taken=1, rdata miss -> read@5 at T+1, write@5 at T+3 with vld=1, tag=0x3, counter=2; rdy high at T+4.
REQ-043 Update hit, rdata counter=3, taken=1 -> written counter=3; hit, counter=0, taken=0 -> written counter=0.
REQ-044 i_pred_req held high, guard enabled, STARVE_LIMIT=8 -> read forced after 8 denied cycles with o_pred_gnt=0 that cycle; write forced after 8 more.
REQ-045 i_pred_req held high, guard disabled -> update stays in RD indefinitely; o_pred_gnt=1 every cycle.
REQ-046 rst asserted in WAIT -> no write strobe; next cycle state IDLE, o_upd_rdy=1, o_busy=0.
REQ-047 Lookup idx=5 one cycle after write@5 -> next-cycle rdata equals the written entry.

Source files
------------

// File: rtl/ftb_update_sched_if.sv
// FTB entry/update types plus the bundled lookup, update and SRAM signals
// of the FTB update scheduler; the slave modport is the scheduler side.
package ftb_pkg;
    localparam int FTB_TAG_WIDTH = 8;

    typedef struct packed {
        logic [11:0] target;
        logic [2:0]  br_type;
        logic [1:0]  counter;
    } ftb_info_t;

    typedef struct packed {
        ftb_info_t ftb_update;
    } BPupdateInfo_t;

    typedef struct packed {
        logic [FTB_TAG_WIDTH-1:0] tag;
        logic                     vld;
        ftb_info_t                info;
    } ftbEntry_t;
endpackage

interface ftb_update_sched_if #(
    parameter int SETS = 512
);
    import ftb_pkg::*;
    localparam int IW = $clog2(SETS);

    logic                     i_pred_req;
    logic [IW-1:0]            i_pred_idx;
    logic                     o_pred_gnt;
    logic                     i_upd_vld;
    logic                     o_upd_rdy;
    logic [IW-1:0]            i_upd_idx;
    logic [FTB_TAG_WIDTH-1:0] i_upd_tag;
    BPupdateInfo_t            i_upd_info;
    logic                     i_upd_taken;
    logic                     o_sram_en;
    logic                     o_sram_we;
    logic [IW-1:0]            o_sram_addr;
    ftbEntry_t                o_sram_wdata;
    ftbEntry_t                i_sram_rdata;
    logic                     o_busy;

    modport master (
        output i_pred_req, i_pred_idx, i_upd_vld, i_upd_idx, i_upd_tag,
               i_upd_info, i_upd_taken, i_sram_rdata,
        input  o_pred_gnt, o_upd_rdy, o_sram_en, o_sram_we, o_sram_addr,
               o_sram_wdata, o_busy
    );

    modport slave (
        input  i_pred_req, i_pred_idx, i_upd_vld, i_upd_idx, i_upd_tag,
               i_upd_info, i_upd_taken, i_sram_rdata,
        output o_pred_gnt, o_upd_rdy, o_sram_en, o_sram_we, o_sram_addr,
               o_sram_wdata, o_busy
    );
endinterface

// File: rtl/ftb_update_sched.sv
// Arbitrates one single-port FTB SRAM between predictor lookups and read-modify-write
// updates. Optional starvation guard: define FTB_UPD_STARVE_GUARD_EN.
module ftb_update_sched
    import ftb_pkg::*;
#(
    parameter int SETS         = 512,
    parameter int STARVE_LIMIT = 8
) (
    input logic               clk,
    input logic               rst,
    ftb_update_sched_if.slave bus
);
    localparam int IW = $clog2(SETS);

    typedef enum logic [1:0] {IDLE, RD, WAIT, WR} state_t;

    state_t                   state_q, state_d, state_cur;
    logic [IW-1:0]            idx_p0;
    logic [FTB_TAG_WIDTH-1:0] tag_p0;
    ftb_info_t                info_p0;
    logic                     taken_p0;
    logic                     merge_vld_p1;
    logic [FTB_TAG_WIDTH-1:0] merge_tag_p1;
    logic [1:0]               merge_ctr_p1;
    logic                     upd_turn, force_win, upd_win, hit, pred_gnt;
    ftbEntry_t                wdata;

    function automatic logic [1:0] sat_ctr2(input logic [1:0] ctr, input logic up);
        if (up) return (ctr == 2'd3) ? 2'd3 : ctr + 2'd1;
        return (ctr == 2'd0) ? 2'd0 : ctr - 2'd1;
    endfunction

    // Reset overrides the registered state so nothing is strobed for a dropped update.
    assign state_cur = rst ? IDLE : state_q;
    assign upd_turn  = (state_cur == RD) || (state_cur == WR);
    assign upd_win   = upd_turn && (!bus.i_pred_req || force_win);

`ifdef FTB_UPD_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_cnt;

    assign force_win = (starve_cnt >= CW'(STARVE_LIMIT));

    // A lost slot implies the counter is still below the limit, so this saturates.
    always_ff @(posedge clk) begin
        if (rst)
            starve_cnt <= '0;
        else if (upd_win)
            starve_cnt <= '0;
        else if (upd_turn)
            starve_cnt <= starve_cnt + 1'b1;
    end
`else
    assign force_win = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.i_upd_vld) state_d = RD;
            RD:   if (upd_win)       state_d = WAIT;
            WAIT:                    state_d = WR;
            WR:   if (upd_win)       state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // p0: update request latched on handshake
    always_ff @(posedge clk) begin
        if (state_q == IDLE && bus.i_upd_vld) begin
            idx_p0   <= bus.i_upd_idx;
            tag_p0   <= bus.i_upd_tag;
            info_p0  <= bus.i_upd_info.ftb_update;
            taken_p0 <= bus.i_upd_taken;
        end
    end

    // p1: SRAM read data merged during WAIT, held until the write wins
    always_ff @(posedge clk) begin
        if (state_q == WAIT) begin
            merge_vld_p1 <= bus.i_sram_rdata.vld;
            merge_tag_p1 <= bus.i_sram_rdata.tag;
            merge_ctr_p1 <= bus.i_sram_rdata.info.counter;
        end
    end

    always_comb begin
        hit                = merge_vld_p1 && (merge_tag_p1 == tag_p0);
        wdata.tag          = tag_p0;
        wdata.vld          = 1'b1;
        wdata.info         = info_p0;
        wdata.info.counter = hit ? sat_ctr2(merge_ctr_p1, taken_p0)
                                 : (taken_p0 ? 2'd2 : 2'd1);
    end

    always_comb begin
        pred_gnt         = bus.i_pred_req && !upd_win;
        bus.o_pred_gnt   = pred_gnt;
        bus.o_upd_rdy    = (state_cur == IDLE);
        bus.o_busy       = (state_cur != IDLE);
        bus.o_sram_en    = pred_gnt || upd_win;
        bus.o_sram_we    = upd_win && (state_cur == WR);
        bus.o_sram_addr  = upd_win ? idx_p0 : bus.i_pred_idx;
        bus.o_sram_wdata = wdata;
    end
endmodule

// File: tb/tb_ftb_update_sched.sv
// Randomized bench for ftb_update_sched: SRAM behavioural model, transaction-level
// reference of the update scheduler, per-cycle compare plus directed literal checks.
module tb_ftb_update_sched;
    import ftb_pkg::*;

    localparam int SETS  = 16;
    localparam int LIMIT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ftb_update_sched_if #(.SETS(SETS)) bus ();

    ftb_update_sched #(.SETS(SETS), .STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        else
            pass_cnt++;
    endtask

    // SRAM model, with a preload port used by the stimulus
    ftbEntry_t mem [SETS];
    logic      pl_en = 1'b0;
    logic [3:0] pl_addr = '0;
    ftbEntry_t pl_data;

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_addr] <= pl_data;
        else if (bus.o_sram_en && bus.o_sram_we)
            mem[bus.o_sram_addr] <= bus.o_sram_wdata;
        if (bus.o_sram_en && !bus.o_sram_we)
            bus.i_sram_rdata <= mem[bus.o_sram_addr];
    end

    // Reference: one pending update walking read -> wait -> write, golden table contents
    ftbEntry_t     gold [SETS];
    int            m_phase = 0;    // 0 none pending, 1 wants read, 2 read returning, 3 wants write
    int            m_deny  = 0;
    logic [3:0]    m_idx;
    logic [7:0]    m_tag;
    ftb_info_t     m_info;
    logic          m_taken;

    function automatic bit m_win();
        bit wants, forced;
        wants  = !rst && (m_phase == 1 || m_phase == 3);
        forced = 1'b0;
`ifdef FTB_UPD_STARVE_GUARD_EN
        forced = (m_deny >= LIMIT);
`endif
        return wants && (!bus.i_pred_req || forced);
    endfunction

    function automatic ftbEntry_t expected_entry();
        ftbEntry_t old, e;
        int c;
        old    = gold[m_idx];
        e.tag  = m_tag;
        e.vld  = 1'b1;
        e.info = m_info;
        if (old.vld && old.tag == m_tag) begin
            c = int'(old.info.counter) + (m_taken ? 1 : -1);
            if (c > 3) c = 3;
            if (c < 0) c = 0;
        end else begin
            c = m_taken ? 2 : 1;
        end
        e.info.counter = 2'(c);
        return e;
    endfunction

    always @(posedge clk) begin
        bit w;
        w = m_win();
        if (pl_en) gold[pl_addr] = pl_data;
        if (rst) begin
            m_phase = 0;
            m_deny  = 0;
        end else begin
            case (m_phase)
                0: if (bus.i_upd_vld) begin
                    m_idx   = bus.i_upd_idx;
                    m_tag   = bus.i_upd_tag;
                    m_info  = bus.i_upd_info.ftb_update;
                    m_taken = bus.i_upd_taken;
                    m_phase = 1;
                end
                1, 3: if (w) begin
                    m_deny = 0;
                    if (m_phase == 3) begin
                        gold[m_idx] = expected_entry();
                        m_phase = 0;
                    end else begin
                        m_phase = 2;
                    end
                end else if (m_deny < LIMIT) begin
                    m_deny = m_deny + 1;
                end
                default: m_phase = 3;
            endcase
        end
    end

    // Compare process: every output, every cycle
    always @(negedge clk) begin
        bit w, gnt, busy;
        w    = m_win();
        gnt  = bus.i_pred_req && !w;
        busy = !rst && (m_phase != 0);
        chk("upd_rdy", 64'(bus.o_upd_rdy), 64'(!busy));
        chk("busy", 64'(bus.o_busy), 64'(busy));
        chk("pred_gnt", 64'(bus.o_pred_gnt), 64'(gnt));
        chk("sram_en", 64'(bus.o_sram_en), 64'(gnt || w));
        chk("sram_we", 64'(bus.o_sram_we), 64'(w && m_phase == 3));
        if (gnt || w)
            chk("sram_addr", 64'(bus.o_sram_addr), 64'(w ? m_idx : bus.i_pred_idx));
        if (w && m_phase == 3)
            chk("sram_wdata", 64'(bus.o_sram_wdata), 64'(expected_entry()));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int a, input ftbEntry_t e);
        pl_en   = 1'b1;
        pl_addr = 4'(a);
        pl_data = e;
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic do_update(input int idx, input logic [7:0] tag, input logic tk, input ftb_info_t inf);
        bus.i_upd_vld           = 1'b1;
        bus.i_upd_idx           = 4'(idx);
        bus.i_upd_tag           = tag;
        bus.i_upd_taken         = tk;
        bus.i_upd_info.ftb_update = inf;
        tick();
        bus.i_upd_vld = 1'b0;
        repeat (4) tick();
    endtask

    task automatic lookup(input int idx, output ftbEntry_t e);
        bus.i_pred_req = 1'b1;
        bus.i_pred_idx = 4'(idx);
        tick();
        bus.i_pred_req = 1'b0;
        @(negedge clk);
        e = bus.i_sram_rdata;
        #1;
    endtask

    function automatic ftbEntry_t mk(input logic [7:0] tag, input logic v, input logic [1:0] c);
        ftbEntry_t e;
        e.tag          = tag;
        e.vld          = v;
        e.info.target  = 12'h5a5;
        e.info.br_type = 3'd2;
        e.info.counter = c;
        return e;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        ftbEntry_t e, exp_e;
        ftb_info_t inf;
        bus.i_pred_req   = 1'b0;
        bus.i_pred_idx   = '0;
        bus.i_upd_vld    = 1'b0;
        bus.i_upd_idx    = '0;
        bus.i_upd_tag    = '0;
        bus.i_upd_taken  = 1'b0;
        bus.i_upd_info   = '0;
        bus.i_sram_rdata = '0;
        pl_data          = '0;
        rst              = 1'b1;

        // Reset: fill table while held in reset; idle outputs expected
        for (int i = 0; i < SETS; i++) begin
            e = ftbEntry_t'($urandom);
            e.tag = 8'($urandom_range(0, 3));
            preload(i, e);
        end
        @(negedge clk);
        chk("rst_rdy", 64'(bus.o_upd_rdy), 64'd1);
        chk("rst_busy", 64'(bus.o_busy), 64'd0);
        chk("rst_en", 64'(bus.o_sram_en), 64'd0);
        tick();
        rst = 1'b0;

        // Miss on idle bus: read@T+1, write@T+3, ready at T+4, lookup sees it
        preload(5, mk(8'h0, 1'b0, 2'd3));
        inf = mk(8'h0, 1'b0, 2'd0).info;
        bus.i_upd_vld = 1'b1; bus.i_upd_idx = 4'd5; bus.i_upd_tag = 8'h3;
        bus.i_upd_taken = 1'b1; bus.i_upd_info.ftb_update = inf;
        @(negedge clk);
        chk("t0_rdy", 64'(bus.o_upd_rdy), 64'd1);
        tick(); bus.i_upd_vld = 1'b0;
        @(negedge clk);
        chk("t1_rd", {bus.o_sram_en, bus.o_sram_we, 4'(bus.o_sram_addr)}, {1'b1, 1'b0, 4'd5});
        tick(); @(negedge clk);
        chk("t2_idle_bus", 64'(bus.o_sram_en), 64'd0);
        tick(); @(negedge clk);
        chk("t3_wr", {bus.o_sram_en, bus.o_sram_we, 4'(bus.o_sram_addr)}, {1'b1, 1'b1, 4'd5});
        exp_e = mk(8'h3, 1'b1, 2'd2);
        chk("t3_wdata", 64'(bus.o_sram_wdata), 64'(exp_e));
        tick(); @(negedge clk);
        chk("t4_rdy", 64'(bus.o_upd_rdy), 64'd1);
        #1;
        lookup(5, e);
        chk("lookup_after_wr", 64'(e), 64'(exp_e));

        // Hit cases: saturation at both ends and a plain decrement
        preload(7, mk(8'h9, 1'b1, 2'd3));
        do_update(7, 8'h9, 1'b1, inf);
        lookup(7, e);
        chk("hit_sat_hi", 64'(e.info.counter), 64'd3);
        preload(8, mk(8'h9, 1'b1, 2'd0));
        do_update(8, 8'h9, 1'b0, inf);
        lookup(8, e);
        chk("hit_sat_lo", 64'(e.info.counter), 64'd0);
        preload(9, mk(8'h4, 1'b1, 2'd1));
        do_update(9, 8'h4, 1'b0, inf);
        lookup(9, e);
        chk("hit_dec", 64'(e.info.counter), 64'd0);
        preload(10, mk(8'h4, 1'b1, 2'd1));
        do_update(10, 8'h6, 1'b0, inf);
        lookup(10, e);
        chk("tag_miss_nt", {e.tag, 2'(e.info.counter)}, {8'h6, 2'd1});

        // Reset during WAIT drops the update
        bus.i_upd_vld = 1'b1; bus.i_upd_idx = 4'd11; bus.i_upd_tag = 8'h2;
        tick(); bus.i_upd_vld = 1'b0;
        tick(); rst = 1'b1;
        @(negedge clk);
        chk("rstwait_we", 64'(bus.o_sram_we), 64'd0);
        chk("rstwait_rdy", 64'(bus.o_upd_rdy), 64'd1);
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("postrst_idle", {bus.o_upd_rdy, bus.o_busy, bus.o_sram_en}, {1'b1, 1'b0, 1'b0});
        #1;
        repeat (3) begin
            tick(); @(negedge clk);
            chk("postrst_no_wr", 64'(bus.o_sram_en), 64'd0);
            #1;
        end

        // Lookups held high against a pending update
        bus.i_pred_req = 1'b1; bus.i_pred_idx = 4'd1;
        bus.i_upd_vld = 1'b1; bus.i_upd_idx = 4'd12; bus.i_upd_tag = 8'h1;
        tick(); bus.i_upd_vld = 1'b0;
`ifdef FTB_UPD_STARVE_GUARD_EN
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge clk); chk("starve_rd_deny", 64'(bus.o_pred_gnt), 64'd1); tick();
        end
        @(negedge clk);
        chk("starve_rd_force", {bus.o_pred_gnt, bus.o_sram_en, bus.o_sram_we}, {1'b0, 1'b1, 1'b0});
        tick(); tick();
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge clk); chk("starve_wr_deny", 64'(bus.o_pred_gnt), 64'd1); tick();
        end
        @(negedge clk);
        chk("starve_wr_force", {bus.o_pred_gnt, bus.o_sram_en, bus.o_sram_we}, {1'b0, 1'b1, 1'b1});
        tick();
`else
        for (int i = 0; i < 3 * LIMIT; i++) begin
            @(negedge clk);
            chk("noguard_gnt", {bus.o_pred_gnt, bus.o_busy, bus.o_sram_we}, {1'b1, 1'b1, 1'b0});
            tick();
        end
`endif
        bus.i_pred_req = 1'b0;
        repeat (4) tick();

        // Randomized traffic; compare process and reference do the checking
        for (int i = 0; i < 3000; i++) begin
            bus.i_pred_req  = ($urandom_range(0, 99) < 60);
            bus.i_pred_idx  = 4'($urandom_range(0, SETS - 1));
            bus.i_upd_vld   = ($urandom_range(0, 99) < 30);
            bus.i_upd_idx   = 4'($urandom_range(0, SETS - 1));
            bus.i_upd_tag   = 8'($urandom_range(0, 3));
            bus.i_upd_taken = 1'($urandom);
            bus.i_upd_info  = BPupdateInfo_t'($urandom);
            rst             = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 1'b0;
        bus.i_pred_req = 1'b0;
        bus.i_upd_vld  = 1'b0;
        repeat (6) tick();
        for (int i = 0; i < SETS; i++)
            chk("table_final", 64'(mem[i]), 64'(gold[i]));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
